// File: rtl/axi_burst_scheduler.sv
// Round-robin scheduler for write/read bursts sharing one AXI address channel.
// Ring-buffer addressing, with reads gated behind completed writes.
module axi_burst_scheduler #(
    parameter logic [2:0]  ASIZE        = 3'h3,
    parameter logic [7:0]  ALEN         = 8'hFF,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          FRAME_BURSTS = 1024,
    parameter logic [7:0]  AID          = 8'h00
) (
    input  logic                            axi_clk,
    input  logic                            rstn,
    input  logic                            enable,
    input  logic                            wr_req,
    output logic                            wr_gnt,
    input  logic                            wr_done,
    input  logic                            rd_req,
    output logic                            rd_gnt,
    output logic [7:0]                      aid,
    output logic [31:0]                     aaddr,
    output logic [7:0]                      alen,
    output logic [2:0]                      asize,
    output logic [1:0]                      aburst,
    output logic [1:0]                      alock,
    output logic                            avalid,
    output logic                            atype,
    input  logic                            aready,
    output logic [$clog2(FRAME_BURSTS):0]   fill_level,
    output logic                            req_overrun
);

    localparam int IW = $clog2(FRAME_BURSTS);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL = CW'(FRAME_BURSTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BURSTS - 1);
    localparam logic [31:0] BURST_BYTES = (32'(ALEN) + 32'd1) << ASIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_GRANT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_wr_pend;
    logic          r_rd_pend;
    logic          r_overrun;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_avail;
    logic          r_last_wr;
    logic [31:0]   r_aaddr;
    logic [7:0]    r_alen;
    logic [2:0]    r_asize;
    logic [1:0]    r_aburst;
    logic [1:0]    r_alock;
    logic          r_atype;

    logic          w_wr_elig;
    logic          w_rd_elig;
    logic          w_pick_wr;
    logic          w_load;
    logic          w_done_ok;
    logic [IW-1:0] w_sel_idx;
    logic [31:0]   w_addr;

    assign w_wr_elig = r_wr_pend && (r_issued < FULL);
    assign w_rd_elig = r_rd_pend && (r_avail != '0);
    // On a tie the side that did not go last wins
    assign w_pick_wr = w_wr_elig && (!w_rd_elig || !r_last_wr);
    assign w_sel_idx = w_pick_wr ? r_wr_idx : r_rd_idx;
    assign w_addr    = BASE_ADDR + 32'(w_sel_idx) * BURST_BYTES;
    assign w_done_ok = wr_done && (r_avail < r_issued);

    assign aid        = AID;
    assign aaddr      = r_aaddr;
    assign alen       = r_alen;
    assign asize      = r_asize;
    assign aburst     = r_aburst;
    assign alock      = r_alock;
    assign atype      = r_atype;
    assign fill_level = r_avail;
    assign req_overrun = r_overrun;

    // State register
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, address-phase valid and grant pulses
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        avalid = 1'b0;
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable && (w_wr_elig || w_rd_elig)) begin
                    w_next = S_ADDR;
                    w_load = 1'b1;
                end
            end
            S_ADDR: begin
                avalid = 1'b1;
                if (aready) w_next = S_GRANT;
            end
            S_GRANT: begin
                wr_gnt = r_atype;
                rd_gnt = !r_atype;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Address fields load on entry to ADDR and hold otherwise
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            r_aaddr  <= '0;
            r_alen   <= '0;
            r_asize  <= '0;
            r_aburst <= '0;
            r_alock  <= '0;
            r_atype  <= 1'b0;
        end else if (w_load) begin
            r_aaddr  <= w_addr;
            r_alen   <= ALEN;
            r_asize  <= ASIZE;
            r_aburst <= 2'b01;
            r_alock  <= 2'b00;
            r_atype  <= w_pick_wr;
        end
    end

    // Request latching; a pulse onto a set flag is dropped and flagged
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_pend <= wr_gnt ? 1'b0 : (r_wr_pend | wr_req);
            r_rd_pend <= rd_gnt ? 1'b0 : (r_rd_pend | rd_req);
            if ((wr_req && r_wr_pend) || (rd_req && r_rd_pend))
                r_overrun <= 1'b1;
        end
    end

    // Ring indices and round-robin history advance on grants
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_last_wr <= 1'b0;
        end else if (wr_gnt) begin
            r_wr_idx  <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 1'b1;
            r_last_wr <= 1'b1;
        end else if (rd_gnt) begin
            r_rd_idx  <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
            r_last_wr <= 1'b0;
        end
    end

    // Occupancy counters: issued writes and completed-but-unread bursts
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            r_issued <= '0;
            r_avail  <= '0;
        end else begin
            if (wr_gnt)      r_issued <= r_issued + 1'b1;
            else if (rd_gnt) r_issued <= r_issued - 1'b1;
            if (rd_gnt && !w_done_ok)      r_avail <= r_avail - 1'b1;
            else if (w_done_ok && !rd_gnt) r_avail <= r_avail + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Randomized bench for axi_burst_scheduler against a transaction model.
// Small ring with a base near 2^32 to exercise both wrap paths.
module tb_axi_burst_scheduler;

    localparam int          FB   = 4;
    localparam logic [31:0] BASE = 32'hFFFF_F000;
    localparam logic [31:0] BB   = 32'h800;

    logic        axi_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        wr_req = 1'b0;
    logic        wr_done = 1'b0;
    logic        rd_req = 1'b0;
    logic        aready = 1'b0;
    logic        wr_gnt, rd_gnt, avalid, atype, req_overrun;
    logic [7:0]  aid, alen;
    logic [31:0] aaddr;
    logic [2:0]  asize;
    logic [1:0]  aburst, alock;
    logic [2:0]  fill_level;

    axi_burst_scheduler #(
        .ASIZE(3'h3), .ALEN(8'hFF), .BASE_ADDR(BASE),
        .FRAME_BURSTS(FB), .AID(8'h00)
    ) dut (
        .axi_clk(axi_clk), .rstn(rstn), .enable(enable),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_done(wr_done),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .aid(aid),
        .aaddr(aaddr), .alen(alen), .asize(asize),
        .aburst(aburst), .alock(alock), .avalid(avalid),
        .atype(atype), .aready(aready), .fill_level(fill_level),
        .req_overrun(req_overrun)
    );

    always #5 axi_clk = ~axi_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what each register should hold this cycle
    int   m_wr_pend, m_rd_pend, m_issued, m_avail;
    int   m_wr_idx, m_rd_idx, m_last_wr, m_ovr;
    bit   e_av, e_type, e_wr_gnt, e_rd_gnt;
    logic [31:0] e_addr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_wr_pend = 0; m_rd_pend = 0; m_issued = 0; m_avail = 0;
        m_wr_idx = 0; m_rd_idx = 0; m_last_wr = 0; m_ovr = 0;
        e_av = 0; e_type = 0; e_wr_gnt = 0; e_rd_gnt = 0; e_addr = '0;
    endtask

    // One clock cycle: check outputs, drive inputs, advance model
    task automatic step(input bit wq, input bit rq, input bit wd,
                        input bit ar, input bit en);
        bit wel, rel, pick, idle, hs, n_av, done_ok, wq_e, rq_e;
        @(negedge axi_clk);
        chk("wr_gnt", wr_gnt, e_wr_gnt);
        chk("rd_gnt", rd_gnt, e_rd_gnt);
        chk("avalid", avalid, e_av);
        chk("fill_level", fill_level, m_avail);
        chk("req_overrun", req_overrun, m_ovr);
        if (e_av) begin
            chk("aaddr", aaddr, e_addr);
            chk("atype", atype, e_type);
            chk("alen", alen, 8'hFF);
            chk("asize", asize, 3'h3);
            chk("aburst", aburst, 2'b01);
            chk("alock", alock, 2'b00);
            chk("aid", aid, 8'h00);
        end
        wq_e = wq && !e_wr_gnt && !e_rd_gnt;
        rq_e = rq && !e_wr_gnt && !e_rd_gnt;
        wr_req = wq_e; rd_req = rq_e; wr_done = wd;
        aready = ar; enable = en;
        wel  = (m_wr_pend != 0) && (m_issued < FB);
        rel  = (m_rd_pend != 0) && (m_avail > 0);
        pick = wel && (!rel || (m_last_wr == 0));
        idle = !e_av && !e_wr_gnt && !e_rd_gnt;
        hs   = e_av && ar;
        n_av = e_av ? !ar : (idle && en && (wel || rel));
        if (!e_av && n_av) begin
            e_type = pick;
            e_addr = BASE + 32'(pick ? m_wr_idx : m_rd_idx) * BB;
        end
        if (wq_e && m_wr_pend != 0) m_ovr = 1;
        if (rq_e && m_rd_pend != 0) m_ovr = 1;
        done_ok = wd && (m_avail < m_issued);
        if (e_wr_gnt) begin
            m_issued++; m_wr_idx = (m_wr_idx + 1) % FB;
            m_last_wr = 1; m_wr_pend = 0;
        end else if (wq_e) m_wr_pend = 1;
        if (e_rd_gnt) begin
            m_issued--; m_avail--; m_rd_idx = (m_rd_idx + 1) % FB;
            m_last_wr = 0; m_rd_pend = 0;
        end else if (rq_e) m_rd_pend = 1;
        if (done_ok) m_avail++;
        e_wr_gnt = hs && e_type;
        e_rd_gnt = hs && !e_type;
        e_av = n_av;
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(0, 0, 0, 1, 1);
    endtask

    initial begin
        int guard;
        m_reset();
        repeat (2) @(negedge axi_clk);
        chk("rst_avalid", avalid, 0);
        chk("rst_atype", atype, 0);
        chk("rst_gnt", {wr_gnt, rd_gnt}, 0);
        chk("rst_ovr", req_overrun, 0);
        chk("rst_aaddr", aaddr, 0);
        chk("rst_fields", {alen, asize, aburst, alock}, 0);
        chk("rst_fill", fill_level, 0);
        rstn = 1'b1;
        enable = 1'b1;
        // Read gating: nothing completed yet
        step(0, 1, 0, 1, 1);
        idle_n(4);
        // Single write, completion, then the waiting read issues
        step(1, 0, 0, 1, 1);
        idle_n(4);
        step(0, 0, 1, 1, 1);
        idle_n(5);
        // Stray done while nothing outstanding
        step(0, 0, 1, 1, 1);
        idle_n(2);
        // Round-robin: last was write, both eligible
        step(1, 0, 0, 1, 1);
        idle_n(4);
        step(0, 0, 1, 1, 1);
        step(1, 1, 0, 1, 1);
        idle_n(8);
        // Backpressure plus a duplicate request while pending
        step(0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        idle_n(4);
        // Drain, then fill the ring and try a fifth write
        guard = 0;
        while ((m_issued > 0 || e_av) && guard < 200) begin
            step(0, m_rd_pend == 0, 1, 1, 1);
            guard++;
        end
        chk("drain", m_issued, 0);
        repeat (4) begin
            step(1, 0, 1, 1, 1);
            idle_n(3);
        end
        step(1, 0, 0, 1, 1);
        idle_n(6);
        step(0, 1, 0, 1, 1);
        idle_n(10);
        // Enable gating with a request pending
        step(0, 1, 0, 1, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        idle_n(4);
        // Randomized traffic
        repeat (3000)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) != 0);
        // Reset during an address phase
        guard = 0;
        while (!(e_av && e_type) && guard < 300) begin
            step(m_wr_pend == 0, m_rd_pend == 0, 1, e_av ? 1'b1 : 1'b0, 1);
            guard++;
        end
        chk("reach_addr", e_av && e_type, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_avalid", avalid, 0);
        chk("rst_mid_gnt", {wr_gnt, rd_gnt}, 0);
        @(negedge axi_clk);
        chk("rst_hold_gnt", {wr_gnt, rd_gnt}, 0);
        chk("rst_hold_fill", fill_level, 0);
        wr_req = 0; rd_req = 0; wr_done = 0; aready = 1;
        m_reset();
        rstn = 1'b1;
        idle_n(6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
